// File: rtl/lsq_issue_queue_pkg.sv
// Shared constants and helpers for the load/store issue queue.
//   ISSUELS_FUNC_SW : opcode value that marks a store; any other value is a load.
//   entry_ready()   : an entry can issue once its base is resolved and, for a
//                     store, its store data is resolved as well.
package lsq_issue_queue_pkg;

   localparam logic ISSUELS_FUNC_SW = 1'b1;

   // Loads never wait on rt: for a load it is the destination tag.
   function automatic logic entry_ready(input logic is_store,
                                        input logic rs_ok,
                                        input logic rt_ok);
      return rs_ok & (rt_ok | ~is_store);
   endfunction

endpackage

// File: rtl/lsq_age_select.sv
// Oldest-eligible selector for the LS issue queue.
// Optional feature macro: LSQ_LOAD_BYPASS_EN
//   undefined : only entry 0 may be chosen (strict FIFO).
//   defined   : a ready load may pass older entries when every one of them is
//               a store with a resolved base whose word address differs.
// Ports:
//   cand    in   DEPTH          entry valid and operand-ready
//   opcode  in   DEPTH          per-entry opcode       (bypass build only)
//   rsvalid in   DEPTH          per-entry base valid   (bypass build only)
//   rsdata  in   DEPTH x DATA_W per-entry base value   (bypass build only)
//   imm     in   DEPTH x DATA_W per-entry offset       (bypass build only)
//   grant   out  DEPTH          one-hot oldest eligible entry
//   idx     out  IDX_W          index of grant (0 when none)
//   any     out  1              some entry is eligible
module lsq_age_select #(
   parameter int unsigned DEPTH  = 4,
`ifdef LSQ_LOAD_BYPASS_EN
   parameter int unsigned DATA_W = 32,
`endif
   parameter int unsigned IDX_W  = 2
) (
   input  logic [DEPTH-1:0]             cand,
`ifdef LSQ_LOAD_BYPASS_EN
   input  logic [DEPTH-1:0]             opcode,
   input  logic [DEPTH-1:0]             rsvalid,
   input  logic [DEPTH-1:0][DATA_W-1:0] rsdata,
   input  logic [DEPTH-1:0][DATA_W-1:0] imm,
`endif
   output logic [DEPTH-1:0]             grant,
   output logic [IDX_W-1:0]             idx,
   output logic                         any
);

   logic [DEPTH-1:0] elig;

`ifdef LSQ_LOAD_BYPASS_EN
   import lsq_issue_queue_pkg::*;

   // Word addresses kept full width (shifted) so no operand bit goes unread.
   logic [DEPTH-1:0][DATA_W-1:0] word;

   always_comb begin
      logic older_ok;
      older_ok = 1'b0;
      word     = '0;
      elig     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         word[i] = (rsdata[i] + imm[i]) >> 2;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         older_ok = 1'b1;
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (j < i) begin
               if (!((opcode[j] == ISSUELS_FUNC_SW) && rsvalid[j] &&
                     (word[j] != word[i]))) begin
                  older_ok = 1'b0;
               end
            end
         end
         elig[i] = cand[i] & ((i == 0) | ((opcode[i] != ISSUELS_FUNC_SW) & older_ok));
      end
   end
`else
   assign elig = cand & DEPTH'(1);
`endif

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (elig[i] && !any) begin
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsq_issue_queue.sv
// Parametrised load/store issue queue between dispatch and the LS issue port.
// DEPTH age-ordered entries (index 0 oldest) with CDB operand wakeup; one
// memory op is presented per cycle.
// Optional feature macro: LSQ_LOAD_BYPASS_EN (oldest safe load may pass
// older stores); undefined gives strict FIFO issue from entry 0.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   dispatch_*                  incoming op fields, dispatch_en request
//   dispatch_ready         out  entry accepted this cycle if dispatch_en
//   cdb_tag/cdb_data/cdb_valid  result broadcast for wakeup
//   issuels_*              out  fields of the selected entry (entry 0 if none)
//   issuels_ready          out  a ready entry is presented
//   issuels_done           in   presented entry consumed this cycle
//   lsq_count              out  occupied entries (registered)
module lsq_issue_queue
   import lsq_issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       dispatch_opcode,
   input  logic [DATA_W-1:0]          dispatch_imm,
   input  logic [TAG_W-1:0]           dispatch_rstag,
   input  logic [TAG_W-1:0]           dispatch_rttag,
   input  logic [DATA_W-1:0]          dispatch_rsdata,
   input  logic [DATA_W-1:0]          dispatch_rtdata,
   input  logic                       dispatch_rsvalid,
   input  logic                       dispatch_rtvalid,
   input  logic                       dispatch_en,
   output logic                       dispatch_ready,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_data,
   input  logic                       cdb_valid,
   output logic                       issuels_opcode,
   output logic [TAG_W-1:0]           issuels_rttag,
   output logic [DATA_W-1:0]          issuels_rtdata,
   output logic [DATA_W-1:0]          issuels_rsdata,
   output logic [DATA_W-1:0]          issuels_imm,
   output logic                       issuels_ready,
   input  logic                       issuels_done,
   output logic [$clog2(DEPTH+1)-1:0] lsq_count
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]             valid_q, opcode_q, rsvalid_q, rtvalid_q;
   logic [DEPTH-1:0][TAG_W-1:0]  rstag_q, rttag_q;
   logic [DEPTH-1:0][DATA_W-1:0] imm_q, rsdata_q, rtdata_q;
   logic [CNT_W-1:0]             count_q;

   logic [DEPTH-1:0]             valid_n, opcode_n, rsvalid_n, rtvalid_n;
   logic [DEPTH-1:0][TAG_W-1:0]  rstag_n, rttag_n;
   logic [DEPTH-1:0][DATA_W-1:0] imm_n, rsdata_n, rtdata_n;
   logic [CNT_W-1:0]             count_n;

   logic [DEPTH-1:0] cand, grant;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_any;
   logic             remove, accept;

   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cand[i] = valid_q[i] & entry_ready(opcode_q[i] == ISSUELS_FUNC_SW,
                                            rsvalid_q[i], rtvalid_q[i]);
      end
   end

   lsq_age_select #(
      .DEPTH  (DEPTH),
`ifdef LSQ_LOAD_BYPASS_EN
      .DATA_W (DATA_W),
`endif
      .IDX_W  (IDX_W)
   ) u_age_select (
      .cand    (cand),
`ifdef LSQ_LOAD_BYPASS_EN
      .opcode  (opcode_q),
      .rsvalid (rsvalid_q),
      .rsdata  (rsdata_q),
      .imm     (imm_q),
`endif
      .grant   (grant),
      .idx     (sel_idx),
      .any     (sel_any)
   );

   assign issuels_ready  = sel_any;
   assign issuels_opcode = opcode_q[sel_idx];
   assign issuels_rttag  = rttag_q[sel_idx];
   assign issuels_rtdata = rtdata_q[sel_idx];
   assign issuels_rsdata = rsdata_q[sel_idx];
   assign issuels_imm    = imm_q[sel_idx];

   assign remove         = issuels_done & sel_any;
   assign dispatch_ready = (count_q != CNT_W'(DEPTH)) | remove;
   assign accept         = dispatch_en & dispatch_ready;
   assign lsq_count      = count_q;

   // Each slot first takes its post-compaction source (itself, or the slot
   // above when at/above the removed entry), then sees the CDB, then may be
   // overwritten by the dispatching op at the first free index.
   always_comb begin
      logic              at_or_above;
      int unsigned       src;
      logic [CNT_W-1:0]  free_idx;
      logic              d_rsvalid, d_rtvalid;
      logic [DATA_W-1:0] d_rsdata, d_rtdata;

      at_or_above = 1'b0;
      src         = 0;
      free_idx    = count_q - CNT_W'(remove);
      valid_n     = '0;
      opcode_n    = '0;
      rsvalid_n   = '0;
      rtvalid_n   = '0;
      rstag_n     = '0;
      rttag_n     = '0;
      imm_n       = '0;
      rsdata_n    = '0;
      rtdata_n    = '0;
      count_n     = count_q + CNT_W'(accept) - CNT_W'(remove);

      d_rsvalid = dispatch_rsvalid;
      d_rsdata  = dispatch_rsdata;
      d_rtvalid = dispatch_rtvalid;
      d_rtdata  = dispatch_rtdata;
      if (cdb_valid && !dispatch_rsvalid && (cdb_tag == dispatch_rstag)) begin
         d_rsvalid = 1'b1;
         d_rsdata  = cdb_data;
      end
      if (cdb_valid && !dispatch_rtvalid && (cdb_tag == dispatch_rttag)) begin
         d_rtvalid = 1'b1;
         d_rtdata  = cdb_data;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         at_or_above = at_or_above | grant[i];
         src = (remove && at_or_above) ? i + 1 : i;
         if (src < DEPTH) begin
            valid_n[i]   = valid_q[IDX_W'(src)];
            opcode_n[i]  = opcode_q[IDX_W'(src)];
            rsvalid_n[i] = rsvalid_q[IDX_W'(src)];
            rtvalid_n[i] = rtvalid_q[IDX_W'(src)];
            rstag_n[i]   = rstag_q[IDX_W'(src)];
            rttag_n[i]   = rttag_q[IDX_W'(src)];
            imm_n[i]     = imm_q[IDX_W'(src)];
            rsdata_n[i]  = rsdata_q[IDX_W'(src)];
            rtdata_n[i]  = rtdata_q[IDX_W'(src)];
         end

         if (valid_n[i] && cdb_valid) begin
            if (!rsvalid_n[i] && (cdb_tag == rstag_n[i])) begin
               rsvalid_n[i] = 1'b1;
               rsdata_n[i]  = cdb_data;
            end
            if (!rtvalid_n[i] && (cdb_tag == rttag_n[i])) begin
               rtvalid_n[i] = 1'b1;
               rtdata_n[i]  = cdb_data;
            end
         end

         if (accept && (CNT_W'(i) == free_idx)) begin
            valid_n[i]   = 1'b1;
            opcode_n[i]  = dispatch_opcode;
            rsvalid_n[i] = d_rsvalid;
            rtvalid_n[i] = d_rtvalid;
            rstag_n[i]   = dispatch_rstag;
            rttag_n[i]   = dispatch_rttag;
            imm_n[i]     = dispatch_imm;
            rsdata_n[i]  = d_rsdata;
            rtdata_n[i]  = d_rtdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= '0;
         opcode_q  <= '0;
         rsvalid_q <= '0;
         rtvalid_q <= '0;
         rstag_q   <= '0;
         rttag_q   <= '0;
         imm_q     <= '0;
         rsdata_q  <= '0;
         rtdata_q  <= '0;
         count_q   <= '0;
      end else begin
         valid_q   <= valid_n;
         opcode_q  <= opcode_n;
         rsvalid_q <= rsvalid_n;
         rtvalid_q <= rtvalid_n;
         rstag_q   <= rstag_n;
         rttag_q   <= rttag_n;
         imm_q     <= imm_n;
         rsdata_q  <= rsdata_n;
         rtdata_q  <= rtdata_n;
         count_q   <= count_n;
      end
   end

endmodule
